// File: rtl/machine_mode_types_pkg.sv
// rtl/machine_mode_types_pkg.sv - machine-mode trap cause codes
package machine_mode_types_pkg;
  localparam logic [3:0] CAUSE_INSN_FAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M     = 4'd11;
endpackage

// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared rv32i pipeline types
package rv32i_types_pkg;
  typedef enum logic [1:0] {
    SEQ     = 2'd0,
    TRAPVEC = 2'd1,
    EPC     = 2'd2
  } npc_sel_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/memory inputs and pipeline control outputs
interface pipe_hazard_ctrl_if;
  import rv32i_types_pkg::*;

  logic       ex_valid;
  logic       dren, dwen;
  logic       halt, ret_insn;
  logic       fault_insn, illegal_insn, breakpoint, ecall_insn;
  logic       branch_taken, jump;
  logic       i_busy, d_busy;
  logic       irq_pending;
  logic [3:0] irq_cause;

  logic       d_req;
  logic       commit;
  logic       pc_en;
  npc_sel_t   npc_sel;
  logic       if_ex_stall, if_ex_flush;
  logic       trap_en, mret_en;
  logic       trap_is_irq;
  logic [3:0] trap_cause;
  logic       halted;

  modport slave (
    input  ex_valid, dren, dwen, halt, ret_insn, fault_insn, illegal_insn,
           breakpoint, ecall_insn, branch_taken, jump, i_busy, d_busy,
           irq_pending, irq_cause,
    output d_req, commit, pc_en, npc_sel, if_ex_stall, if_ex_flush,
           trap_en, mret_en, trap_is_irq, trap_cause, halted
  );

  modport master (
    output ex_valid, dren, dwen, halt, ret_insn, fault_insn, illegal_insn,
           breakpoint, ecall_insn, branch_taken, jump, i_busy, d_busy,
           irq_pending, irq_cause,
    input  d_req, commit, pc_en, npc_sel, if_ex_stall, if_ex_flush,
           trap_en, mret_en, trap_is_irq, trap_cause, halted
  );
endinterface

// File: rtl/dwait_timer.sv
// rtl/dwait_timer.sv - counts cycles spent waiting on the data memory
module dwait_timer #(
  parameter int DWAIT_TIMEOUT = 64,
  parameter int CNT_W         = $clog2(DWAIT_TIMEOUT)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expired on the last allowed wait cycle, so the fault is raised in that same cycle.
  assign expired = (cnt_q == CNT_W'(DWAIT_TIMEOUT - 1));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - fetch/execute sequencing: stalls, flushes, commit, traps, MRET, halt
module pipe_hazard_ctrl
  import machine_mode_types_pkg::*;
  import rv32i_types_pkg::*;
#(
  parameter int DWAIT_TIMEOUT = 64,
  parameter int CNT_W         = $clog2(DWAIT_TIMEOUT)
) (
  input logic               CLK,
  input logic               nRST,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_RUN, S_DWAIT, S_TRAP, S_RET, S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] trap_cause_q, trap_cause_d;
  logic       trap_is_irq_q, trap_is_irq_d;
  logic       tmr_clear, tmr_en, tmr_expired;
  logic       mem_op, exc_any, redirect;

  assign mem_op   = bus.dren | bus.dwen;
  assign exc_any  = bus.fault_insn | bus.illegal_insn | bus.breakpoint | bus.ecall_insn;
  assign redirect = bus.branch_taken | bus.jump;

  dwait_timer #(
    .DWAIT_TIMEOUT(DWAIT_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_dwait_timer (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d         = state_q;
    trap_cause_d    = trap_cause_q;
    trap_is_irq_d   = trap_is_irq_q;
    tmr_clear       = 1'b0;
    tmr_en          = 1'b0;
    bus.d_req       = 1'b0;
    bus.commit      = 1'b0;
    bus.pc_en       = 1'b0;
    bus.npc_sel     = SEQ;
    bus.if_ex_stall = 1'b0;
    bus.if_ex_flush = 1'b0;
    bus.trap_en     = 1'b0;
    bus.mret_en     = 1'b0;
    bus.halted      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        tmr_clear = 1'b1;
        if (!bus.ex_valid) begin
          bus.pc_en       = !bus.i_busy;
          bus.if_ex_flush = bus.i_busy;
        end else if (bus.halt) begin
          bus.if_ex_stall = 1'b1;
          state_d         = S_HALT;
        end else if (exc_any) begin
          bus.if_ex_stall = 1'b1;
          trap_is_irq_d   = 1'b0;
          trap_cause_d    = bus.fault_insn   ? CAUSE_INSN_FAULT :
                            bus.illegal_insn ? CAUSE_ILLEGAL    :
                            bus.breakpoint   ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
          state_d         = S_TRAP;
        end else if (bus.irq_pending && !mem_op) begin
          // No commit here: the interrupted instruction re-executes after the handler.
          bus.if_ex_stall = 1'b1;
          trap_is_irq_d   = 1'b1;
          trap_cause_d    = bus.irq_cause;
          state_d         = S_TRAP;
        end else if (bus.ret_insn) begin
          bus.commit      = 1'b1;
          bus.if_ex_stall = 1'b1;
          state_d         = S_RET;
        end else if (mem_op && bus.d_busy) begin
          bus.d_req       = 1'b1;
          bus.if_ex_stall = 1'b1;
          state_d         = S_DWAIT;
        end else begin
          bus.d_req       = mem_op;
          bus.commit      = 1'b1;
          bus.pc_en       = !bus.i_busy;
          bus.if_ex_flush = redirect | bus.i_busy;
        end
      end
      S_DWAIT: begin
        tmr_en = 1'b1;
        if (!bus.d_busy) begin
          bus.d_req       = 1'b1;
          bus.commit      = 1'b1;
          bus.pc_en       = !bus.i_busy;
          bus.if_ex_flush = redirect | bus.i_busy;
          state_d         = S_RUN;
        end else if (tmr_expired) begin
          bus.if_ex_stall = 1'b1;
          trap_is_irq_d   = 1'b0;
          trap_cause_d    = bus.dwen ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
          state_d         = S_TRAP;
        end else begin
          bus.d_req       = 1'b1;
          bus.if_ex_stall = 1'b1;
        end
      end
      S_TRAP: begin
        bus.trap_en     = 1'b1;
        bus.npc_sel     = TRAPVEC;
        bus.pc_en       = 1'b1;
        bus.if_ex_flush = 1'b1;
        state_d         = S_RUN;
      end
      S_RET: begin
        bus.mret_en     = 1'b1;
        bus.npc_sel     = EPC;
        bus.pc_en       = 1'b1;
        bus.if_ex_flush = 1'b1;
        state_d         = S_RUN;
      end
      S_HALT: begin
        bus.halted      = 1'b1;
        bus.if_ex_stall = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= S_RUN;
      trap_cause_q  <= '0;
      trap_is_irq_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trap_cause_q  <= trap_cause_d;
      trap_is_irq_q <= trap_is_irq_d;
    end
  end

  assign bus.trap_cause  = trap_cause_q;
  assign bus.trap_is_irq = trap_is_irq_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench with per-cycle reference model for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int TMO = 8;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.DWAIT_TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: halted flag, pending one-cycle redirect (1 trap, 2 mret),
  // number of cycles already spent waiting on data (-1 when not waiting), latched trap info.
  bit m_halted = 0, nx_halted = 0;
  int m_redirect = 0, nx_redirect = 0;
  int m_waited = -1, nx_waited = -1;
  int m_cause = 0, nx_cause = 0;
  int m_irq = 0, nx_irq = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_halted = 0; m_redirect = 0; m_waited = -1; m_cause = 0; m_irq = 0;
    end else begin
      m_halted = nx_halted; m_redirect = nx_redirect; m_waited = nx_waited;
      m_cause = nx_cause; m_irq = nx_irq;
    end
  end

  always @(negedge CLK) begin : model_cmp
    int e_dreq, e_commit, e_pcen, e_npc, e_stall, e_flush, e_trap, e_mret, e_halted;
    int ib, fwd_fl, is_mem;
    e_dreq = 0; e_commit = 0; e_pcen = 0; e_npc = 0; e_stall = 0;
    e_flush = 0; e_trap = 0; e_mret = 0; e_halted = 0;
    nx_halted = m_halted; nx_redirect = 0; nx_waited = -1; nx_cause = m_cause; nx_irq = m_irq;
    ib     = int'(bus.i_busy);
    fwd_fl = int'(bus.branch_taken | bus.jump | bus.i_busy);
    is_mem = int'(bus.dren | bus.dwen);
    if (m_halted) begin
      e_halted = 1; e_stall = 1;
    end else if (m_redirect != 0) begin
      e_trap = int'(m_redirect == 1); e_mret = int'(m_redirect == 2);
      e_npc = m_redirect; e_pcen = 1; e_flush = 1;
    end else if (m_waited >= 0) begin
      if (!bus.d_busy) begin
        e_dreq = 1; e_commit = 1; e_pcen = 1 - ib; e_flush = fwd_fl;
      end else if (m_waited == TMO - 1) begin
        e_stall = 1; nx_redirect = 1; nx_irq = 0; nx_cause = bus.dwen ? 7 : 5;
      end else begin
        e_dreq = 1; e_stall = 1; nx_waited = m_waited + 1;
      end
    end else if (!bus.ex_valid) begin
      e_pcen = 1 - ib; e_flush = ib;
    end else if (bus.halt) begin
      e_stall = 1; nx_halted = 1;
    end else if (bus.fault_insn | bus.illegal_insn | bus.breakpoint | bus.ecall_insn) begin
      e_stall = 1; nx_redirect = 1; nx_irq = 0;
      nx_cause = bus.fault_insn ? 1 : bus.illegal_insn ? 2 : bus.breakpoint ? 3 : 11;
    end else if (bus.irq_pending && is_mem == 0) begin
      e_stall = 1; nx_redirect = 1; nx_irq = 1; nx_cause = int'(bus.irq_cause);
    end else if (bus.ret_insn) begin
      e_commit = 1; e_stall = 1; nx_redirect = 2;
    end else if (is_mem == 1 && bus.d_busy) begin
      e_dreq = 1; e_stall = 1; nx_waited = 0;
    end else begin
      e_dreq = is_mem; e_commit = 1; e_pcen = 1 - ib; e_flush = fwd_fl;
    end
    check("cyc d_req",       int'(bus.d_req),       e_dreq);
    check("cyc commit",      int'(bus.commit),      e_commit);
    check("cyc pc_en",       int'(bus.pc_en),       e_pcen);
    check("cyc npc_sel",     int'(bus.npc_sel),     e_npc);
    check("cyc if_ex_stall", int'(bus.if_ex_stall), e_stall);
    check("cyc if_ex_flush", int'(bus.if_ex_flush), e_flush);
    check("cyc trap_en",     int'(bus.trap_en),     e_trap);
    check("cyc mret_en",     int'(bus.mret_en),     e_mret);
    check("cyc halted",      int'(bus.halted),      e_halted);
    check("cyc trap_cause",  int'(bus.trap_cause),  m_cause);
    check("cyc trap_is_irq", int'(bus.trap_is_irq), m_irq);
  end

  task automatic clr_in();
    bus.ex_valid = 0; bus.dren = 0; bus.dwen = 0; bus.halt = 0; bus.ret_insn = 0;
    bus.fault_insn = 0; bus.illegal_insn = 0; bus.breakpoint = 0; bus.ecall_insn = 0;
    bus.branch_taken = 0; bus.jump = 0; bus.i_busy = 0; bus.d_busy = 0;
    bus.irq_pending = 0; bus.irq_cause = 4'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    clr_in();
    repeat (2) @(negedge CLK);
    check("rst trap_cause", int'(bus.trap_cause), 0);
    check("rst halted", int'(bus.halted), 0);
    check("rst pc_en", int'(bus.pc_en), 1);
    check("rst d_req", int'(bus.d_req), 0);
    tick(); nRST = 1;

    bus.ex_valid = 1; @(negedge CLK);
    check("alu commit", int'(bus.commit), 1);
    check("alu pc_en", int'(bus.pc_en), 1);
    check("alu flush", int'(bus.if_ex_flush), 0);
    tick(); bus.i_busy = 1; @(negedge CLK);
    check("ibusy pc_en", int'(bus.pc_en), 0);
    check("ibusy flush", int'(bus.if_ex_flush), 1);
    check("ibusy commit", int'(bus.commit), 1);

    tick(); bus.i_busy = 0; bus.dren = 1; bus.d_busy = 1; @(negedge CLK);
    check("ld0 d_req", int'(bus.d_req), 1);
    check("ld0 stall", int'(bus.if_ex_stall), 1);
    check("ld0 commit", int'(bus.commit), 0);
    for (int i = 1; i < 3; i++) begin
      tick(); @(negedge CLK);
      check("ldw d_req", int'(bus.d_req), 1);
      check("ldw commit", int'(bus.commit), 0);
    end
    tick(); bus.d_busy = 0; @(negedge CLK);
    check("ld3 d_req", int'(bus.d_req), 1);
    check("ld3 commit", int'(bus.commit), 1);
    check("ld3 stall", int'(bus.if_ex_stall), 0);

    tick(); bus.dren = 0; bus.dwen = 1; bus.d_busy = 1; @(negedge CLK);
    check("st0 d_req", int'(bus.d_req), 1);
    for (int i = 0; i < TMO; i++) begin
      tick(); @(negedge CLK);
      check("stw d_req", int'(bus.d_req), (i < TMO - 1) ? 1 : 0);
      check("stw commit", int'(bus.commit), 0);
    end
    tick(); bus.dwen = 0; bus.d_busy = 0; @(negedge CLK);
    check("sto trap_en", int'(bus.trap_en), 1);
    check("sto cause", int'(bus.trap_cause), 7);
    check("sto npc_sel", int'(bus.npc_sel), 1);
    check("sto commit", int'(bus.commit), 0);

    tick(); bus.illegal_insn = 1; bus.ecall_insn = 1; bus.irq_pending = 1; bus.irq_cause = 4'd7;
    @(negedge CLK);
    check("exc commit", int'(bus.commit), 0);
    check("exc pc_en", int'(bus.pc_en), 0);
    check("exc stall", int'(bus.if_ex_stall), 1);
    tick(); bus.illegal_insn = 0; bus.ecall_insn = 0; bus.irq_pending = 0; @(negedge CLK);
    check("exc trap_en", int'(bus.trap_en), 1);
    check("exc cause", int'(bus.trap_cause), 2);
    check("exc is_irq", int'(bus.trap_is_irq), 0);

    tick(); bus.irq_pending = 1; bus.irq_cause = 4'd7; @(negedge CLK);
    check("irq commit", int'(bus.commit), 0);
    tick(); bus.irq_pending = 0; @(negedge CLK);
    check("irq trap_en", int'(bus.trap_en), 1);
    check("irq is_irq", int'(bus.trap_is_irq), 1);
    check("irq cause", int'(bus.trap_cause), 7);
    tick(); bus.irq_pending = 1; bus.dren = 1; @(negedge CLK);
    check("irqld commit", int'(bus.commit), 1);
    check("irqld d_req", int'(bus.d_req), 1);
    tick(); bus.irq_pending = 0; bus.dren = 0; @(negedge CLK);
    check("irqld no trap", int'(bus.trap_en), 0);

    tick(); bus.ret_insn = 1; @(negedge CLK);
    check("ret commit", int'(bus.commit), 1);
    check("ret pc_en", int'(bus.pc_en), 0);
    tick(); bus.ret_insn = 0; @(negedge CLK);
    check("ret mret_en", int'(bus.mret_en), 1);
    check("ret npc_sel", int'(bus.npc_sel), 2);
    check("ret flush", int'(bus.if_ex_flush), 1);

    tick(); bus.branch_taken = 1; bus.fault_insn = 1; @(negedge CLK);
    check("brx flush", int'(bus.if_ex_flush), 0);
    check("brx pc_en", int'(bus.pc_en), 0);
    tick(); bus.branch_taken = 0; bus.fault_insn = 0; @(negedge CLK);
    check("brx trap_en", int'(bus.trap_en), 1);
    check("brx cause", int'(bus.trap_cause), 1);

    tick(); bus.halt = 1; @(negedge CLK);
    check("hlt stall", int'(bus.if_ex_stall), 1);
    check("hlt pc_en", int'(bus.pc_en), 0);
    tick(); bus.halt = 0; tick(); tick(); @(negedge CLK);
    check("hlt sticky", int'(bus.halted), 1);
    check("hlt pc_en2", int'(bus.pc_en), 0);
    tick(); nRST = 0; #1;
    check("hlt rst", int'(bus.halted), 0);

    tick(); nRST = 1; bus.dren = 1; bus.d_busy = 1; @(negedge CLK);
    check("rdw d_req0", int'(bus.d_req), 1);
    tick(); @(negedge CLK);
    check("rdw d_req1", int'(bus.d_req), 1);
    tick(); #1; nRST = 0; bus.ex_valid = 0; #1;
    check("rdw async drop", int'(bus.d_req), 0);
    tick(); nRST = 1; clr_in(); bus.ex_valid = 1; @(negedge CLK);
    check("post commit", int'(bus.commit), 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
